urv_divide: RTL and testbench

- Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage next to urv_multiply and is fed from the same decode-stage operands (d_rs1_i, d_rs2_i, d_fun_i).
- Produces a registered writeback result and holds the pipeline stalled while the division runs.
- Restoring algorithm, one quotient bit per clock, with a short path for divide-by-zero and signed overflow.

---
 rtl/urv_divide.sv | 85 ++++++++
 tb/tb_urv_divide.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/urv_divide.sv
// urv_divide: iterative restoring 32-bit divider for RV32M DIV/DIVU/REM/REMU
module urv_divide #(
  parameter bit G_FAST_SPECIAL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        d_start_i,
  input  logic [2:0]  d_fun_i,
  input  logic [31:0] d_rs1_i,
  input  logic [31:0] d_rs2_i,
  input  logic        x_kill_i,
  output logic        x_stall_req_o,
  output logic        w_valid_o,
  output logic [31:0] w_rd_o
);
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
  state_t      state;
  logic [1:0]  fun;
  logic        neg_q, neg_r;
  logic [31:0] rem, quo, div;
  logic [4:0]  cnt;
  logic        is_signed, div_zero, ovf, fast, accept, ge;
  logic [31:0] abs_a, abs_b, special_rd;
  logic [32:0] shifted, trial;
  assign is_signed  = ~d_fun_i[0];
  assign abs_a      = (is_signed && d_rs1_i[31]) ? -d_rs1_i : d_rs1_i;
  assign abs_b      = (is_signed && d_rs2_i[31]) ? -d_rs2_i : d_rs2_i;
  assign div_zero   = d_rs2_i == 32'h0;
  assign ovf        = is_signed && d_rs1_i == 32'h8000_0000 && d_rs2_i == 32'hFFFF_FFFF;
  assign fast       = G_FAST_SPECIAL && (div_zero || ovf);
  assign accept     = state == IDLE && d_start_i && !x_kill_i;
  assign special_rd = d_fun_i[1] ? (div_zero ? d_rs1_i : 32'h0) : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);
  // rem never exceeds 31 significant bits before a shift, so the 33-bit trial sign is exact
  assign shifted    = {rem, quo[31]};
  assign trial      = shifted - {1'b0, div};
  assign ge         = ~trial[32];
  assign x_stall_req_o = (accept && !fast) || state == CALC || state == SIGN;
  // sequencer: load operands, iterate one quotient bit per cycle, fix signs, pulse result
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      fun       <= 2'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      rem       <= 32'h0;
      quo       <= 32'h0;
      div       <= 32'h0;
      cnt       <= 5'd0;
      w_valid_o <= 1'b0;
      w_rd_o    <= 32'h0;
    end else begin
      w_valid_o <= 1'b0;
      if (x_kill_i && state != IDLE) state <= IDLE;
      else case (state)
        IDLE: if (accept) begin
          fun   <= d_fun_i[1:0];
          // a zero divisor must yield all-ones regardless of dividend sign
          neg_q <= is_signed && (d_rs1_i[31] ^ d_rs2_i[31]) && !div_zero;
          neg_r <= is_signed && d_rs1_i[31];
          rem   <= 32'h0;
          quo   <= abs_a;
          div   <= abs_b;
          cnt   <= 5'd0;
          if (fast) begin
            w_rd_o    <= special_rd;
            w_valid_o <= 1'b1;
            state     <= DONE;
          end else state <= CALC;
        end
        CALC: begin
          rem   <= ge ? trial[31:0] : shifted[31:0];
          quo   <= {quo[30:0], ge};
          cnt   <= cnt + 5'd1;
          state <= cnt == 5'd31 ? SIGN : CALC;
        end
        SIGN: begin
          w_rd_o    <= fun[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
          w_valid_o <= 1'b1;
          state     <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_urv_divide.sv
// tb_urv_divide: scoreboard bench comparing fast and slow special-path dividers to an arithmetic model
module tb_urv_divide;
  logic        clk = 1'b0;
  logic        rst_n, start, kill;
  logic [2:0]  fun;
  logic [31:0] rs1, rs2;
  logic        stall_f, valid_f, stall_s, valid_s;
  logic [31:0] rd_f, rd_s;
  int          cyc = 0;
  int          st_f = 0, st_s = 0;
  int          checks = 0, fails = 0;
  typedef struct {
    logic [31:0] rd;
    int lat;
    int stl;
    int cyc0;
    int base;
  } item_t;
  item_t q_f[$];
  item_t q_s[$];

  urv_divide #(.G_FAST_SPECIAL(1'b1)) u_fast (
    .clk_i(clk), .rst_n_i(rst_n), .d_start_i(start), .d_fun_i(fun),
    .d_rs1_i(rs1), .d_rs2_i(rs2), .x_kill_i(kill),
    .x_stall_req_o(stall_f), .w_valid_o(valid_f), .w_rd_o(rd_f)
  );
  urv_divide #(.G_FAST_SPECIAL(1'b0)) u_slow (
    .clk_i(clk), .rst_n_i(rst_n), .d_start_i(start), .d_fun_i(fun),
    .d_rs1_i(rs1), .d_rs2_i(rs2), .x_kill_i(kill),
    .x_stall_req_o(stall_s), .w_valid_o(valid_s), .w_rd_o(rd_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_rd(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
    if (!f[0]) return f[1] ? sa % sb : sa / sb;
    return f[1] ? a % b : a / b;
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return b == 32'h0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    item_t it;
    forever begin
      @(negedge clk);
      if (stall_f) st_f++;
      if (stall_s) st_s++;
      if (valid_f) begin
        if (q_f.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_valid_fast actual=%h required=no_result", rd_f);
        end else begin
          it = q_f.pop_front();
          chk("rd_fast", rd_f, it.rd);
          chk("latency_fast", 32'(cyc - it.cyc0), 32'(it.lat));
          chk("stall_cycles_fast", 32'(st_f - it.base), 32'(it.stl));
        end
      end
      if (valid_s) begin
        if (q_s.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_valid_slow actual=%h required=no_result", rd_s);
        end else begin
          it = q_s.pop_front();
          chk("rd_slow", rd_s, it.rd);
          chk("latency_slow", 32'(cyc - it.cyc0), 32'(it.lat));
          chk("stall_cycles_slow", 32'(st_s - it.base), 32'(it.stl));
        end
      end
    end
  endtask

  // entered and left a few time units after a rising edge
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit push);
    item_t it;
    logic [31:0] e;
    bit sp;
    int bf, bs;
    e  = ref_rd(f, a, b);
    sp = is_special(f, a, b);
    fun = f;
    rs1 = a;
    rs2 = b;
    start = 1'b1;
    bf = st_f;
    bs = st_s;
    @(posedge clk);
    #1;
    if (push) begin
      it.rd   = e;
      it.cyc0 = cyc;
      it.lat  = sp ? 0 : 33;
      it.stl  = sp ? 0 : 34;
      it.base = bf;
      q_f.push_back(it);
      it.lat  = 33;
      it.stl  = 34;
      it.base = bs;
      q_s.push_back(it);
    end
    start = 1'b0;
    rs1 = $urandom;
    rs2 = $urandom;
    fun = 3'(4 + $urandom_range(0, 3));
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q_f.size() != 0 || q_s.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("result_timeout", 32'(q_f.size() == 0 && q_s.size() == 0), 32'd1);
    q_f.delete();
    q_s.delete();
    #2;
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    issue(f, a, b, 1'b1);
    wait_done();
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    rst_n = 1'b0;
    start = 1'b0;
    kill  = 1'b0;
    fun   = 3'b101;
    rs1   = 32'h0;
    rs2   = 32'h0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #2;
    chk("reset_valid", 32'({valid_f, valid_s}), 32'd0);
    chk("reset_rd_fast", rd_f, 32'h0);
    chk("reset_rd_slow", rd_s, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    do_op(3'b101, 32'd100, 32'd7);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2);
    do_op(3'b111, 32'hFFFF_FFF9, 32'd2);
    do_op(3'b101, 32'h1234, 32'h0);
    do_op(3'b111, 32'h1234, 32'h0);
    do_op(3'b100, 32'hFFFF_FF00, 32'h0);
    do_op(3'b110, 32'hFFFF_FF00, 32'h0);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'b111, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    // abort at counter=10, then restart on the very next cycle
    issue(3'b101, 32'd50, 32'd5, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    kill = 1'b1;
    @(posedge clk);
    #2;
    kill = 1'b0;
    chk("kill_stall", 32'({stall_f, stall_s}), 32'd0);
    chk("kill_valid", 32'({valid_f, valid_s}), 32'd0);
    do_op(3'b101, 32'd9, 32'd3);
    // kill coinciding with a start request must not start anything
    kill = 1'b1;
    start = 1'b1;
    fun = 3'b101;
    #1;
    chk("kill_start_stall", 32'({stall_f, stall_s}), 32'd0);
    @(posedge clk);
    #2;
    start = 1'b0;
    kill = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    // asynchronous reset in the middle of CALC
    issue(3'b101, 32'hDEAD_BEEF, 32'd17, 1'b0);
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'({valid_f, valid_s}), 32'd0);
    chk("async_reset_rd_fast", rd_f, 32'h0);
    chk("async_reset_rd_slow", rd_s, 32'h0);
    chk("async_reset_stall", 32'({stall_f, stall_s}), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    do_op(3'b101, 32'hFFFF_FFFF, 32'd1);
    for (int i = 0; i < 40; i++) begin
      f = 3'(4 + $urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = 32'(-$urandom_range(1, 15));
        4: a = $urandom_range(0, 100);
        default: ;
      endcase
      do_op(f, a, b);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
